dram_burst_writer: RTL and testbench



---
 rtl/dram_burst_writer.sv | 184 ++++++++++++++++++
 tb/tb_dram_burst_writer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_writer.sv
// Buffers capture data words and burst commands, then issues them as AXI4 INCR
// write bursts (one outstanding), split so that no burst crosses a 4 KB page.
module dram_burst_writer #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          DATA_DEPTH_LOG2 = 9,
    parameter int          CMD_DEPTH_LOG2  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [35:0] data_in,
    input  logic        data_we,
    input  logic [39:0] ctrl_in,
    input  logic        ctrl_we,
    output logic        data_full,
    output logic        ctrl_full,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        busy,
    output logic [2:0]  err
);
    localparam int DDEPTH = 1 << DATA_DEPTH_LOG2;
    localparam int CDEPTH = 1 << CMD_DEPTH_LOG2;
    localparam int DCW    = DATA_DEPTH_LOG2 + 1;
    localparam int CCW    = CMD_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

    // ---------------- data FIFO (first-word-fall-through) ----------------
    logic [35:0]                dmem [DDEPTH];
    logic [DATA_DEPTH_LOG2-1:0] dwr_q, drd_q;
    logic [DCW-1:0]             data_count_q;
    logic                       d_push, d_pop;
    logic [35:0]                d_head;

    assign data_full = (data_count_q == DCW'(DDEPTH));
    assign d_push    = data_we & ~data_full;
    assign d_head    = dmem[drd_q];

    always_ff @(posedge clk) begin
        if (d_push) dmem[dwr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwr_q        <= '0;
            drd_q        <= '0;
            data_count_q <= '0;
        end else begin
            if (d_push) dwr_q <= dwr_q + 1'b1;
            if (d_pop)  drd_q <= drd_q + 1'b1;
            data_count_q <= data_count_q + DCW'(d_push) - DCW'(d_pop);
        end
    end

    // ---------------- command FIFO (first-word-fall-through) ----------------
    logic [39:0]               cmem [CDEPTH];
    logic [CMD_DEPTH_LOG2-1:0] cwr_q, crd_q;
    logic [CCW-1:0]            ccnt_q;
    logic                      c_len0, c_push, c_pop;
    logic [7:0]                head_len;
    logic [31:0]               head_addr;

    assign ctrl_full = (ccnt_q == CCW'(CDEPTH));
    assign c_len0    = (ctrl_in[39:32] == 8'd0);
    assign c_push    = ctrl_we & ~c_len0 & ~ctrl_full;
    assign head_len  = cmem[crd_q][39:32];
    assign head_addr = cmem[crd_q][31:0];

    always_ff @(posedge clk) begin
        if (c_push) cmem[cwr_q] <= ctrl_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cwr_q  <= '0;
            crd_q  <= '0;
            ccnt_q <= '0;
        end else begin
            if (c_push) cwr_q <= cwr_q + 1'b1;
            if (c_pop)  crd_q <= crd_q + 1'b1;
            ccnt_q <= ccnt_q + CCW'(c_push) - CCW'(c_pop);
        end
    end

    // ---------------- burst FSM ----------------
    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  piece_q, piece_d;
    logic [7:0]  beat_q, beat_d;
    logic [2:0]  err_q, err_d;
    logic [12:0] page_left;
    logic [10:0] room;
    logic [7:0]  piece;
    logic        load, bresp_bad;

    // Words left before the next 4 KB page boundary; rem_q <= 255 so piece fits 8 bits.
    assign page_left = 13'd4096 - {1'b0, addr_q[11:0]};
    assign room      = page_left[12:2];
    assign piece     = ({3'b000, rem_q} < room) ? rem_q : room[7:0];

    // A command starts only once all of its words (full length, not the piece) are buffered.
    assign load      = (state_q == IDLE) && (ccnt_q != '0) && (data_count_q >= DCW'(head_len));
    assign c_pop     = load;
    assign d_pop     = (state_q == DATA) & m_axi_wready;
    assign bresp_bad = (state_q == RESP) & m_axi_bvalid & (m_axi_bresp != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            piece_q <= '0;
            beat_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            piece_q <= piece_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        piece_d = piece_q;
        beat_d  = beat_q;
        err_d   = err_q | {(ctrl_we & c_len0) | bresp_bad,
                           ctrl_we & ~c_len0 & ctrl_full,
                           data_we & data_full};
        unique case (state_q)
            IDLE: if (load) begin
                addr_d  = head_addr + BASE_ADDR;
                rem_d   = head_len;
                state_d = ADDR;
            end
            ADDR: if (m_axi_awready) begin
                // Advance to the next piece now; addr/len outputs are only driven in ADDR.
                piece_d = piece;
                addr_d  = addr_q + {22'd0, piece, 2'b00};
                rem_d   = rem_q - piece;
                beat_d  = '0;
                state_d = DATA;
            end
            DATA: if (m_axi_wready) begin
                beat_d = beat_q + 1'b1;
                if (beat_q == piece_q - 8'd1) state_d = RESP;
            end
            RESP: if (m_axi_bvalid) state_d = (rem_q != 8'd0) ? ADDR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_axi_awsize  = 3'b010;
        m_axi_awburst = 2'b01;
        m_axi_awvalid = (state_q == ADDR);
        m_axi_awaddr  = (state_q == ADDR) ? addr_q : 32'd0;
        m_axi_awlen   = (state_q == ADDR) ? piece - 8'd1 : 8'd0;
        m_axi_wvalid  = (state_q == DATA);
        m_axi_wdata   = (state_q == DATA) ? d_head[31:0] : 32'd0;
        m_axi_wstrb   = (state_q == DATA) ? d_head[35:32] : 4'd0;
        m_axi_wlast   = (state_q == DATA) && (beat_q == piece_q - 8'd1);
        m_axi_bready  = (state_q == RESP);
        busy          = (state_q != IDLE);
        err           = err_q;
    end
endmodule

// File: tb/tb_dram_burst_writer.sv
// Self-checking bench: data scoreboard on the W channel, table of commands with
// expected AW splits, and hand sequences for ordering, overflow and reset corners.
module tb_dram_burst_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [35:0] data_in;
    logic        data_we;
    logic [39:0] ctrl_in;
    logic        ctrl_we;
    logic        data_full, ctrl_full;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        busy;
    logic [2:0]  err;

    dram_burst_writer dut (
        .clk(clk), .rst_n(rst_n),
        .data_in(data_in), .data_we(data_we), .ctrl_in(ctrl_in), .ctrl_we(ctrl_we),
        .data_full(data_full), .ctrl_full(ctrl_full),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- AXI slave model ----------------
    int         aw_dly = 0;
    bit         wrand = 1'b0;
    logic [1:0] bresp_cfg = 2'b00;
    int         aw_wait = 0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            m_axi_bresp   = 2'b00;
            aw_wait       = 0;
        end else begin
            if (m_axi_awvalid) begin
                m_axi_awready = (aw_wait >= aw_dly);
                aw_wait++;
            end else begin
                m_axi_awready = 1'b0;
                aw_wait       = 0;
            end
            m_axi_wready = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_bvalid = m_axi_bready;
            m_axi_bresp  = bresp_cfg;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [35:0] exp_data[$];
    logic [39:0] got_aw[$];
    int          b_cnt = 0;
    int          w_beats = 0;
    int          cur_len = 0;
    int          beat = 0;
    bit          aw_hold = 1'b0, w_hold = 1'b0;
    logic [39:0] aw_prev;
    logic [36:0] w_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_hold = 1'b0;
            w_hold  = 1'b0;
            beat    = 0;
        end else begin
            if (m_axi_awvalid) begin
                if (aw_hold) chk("aw_stable", {m_axi_awaddr, m_axi_awlen}, aw_prev);
                aw_prev = {m_axi_awaddr, m_axi_awlen};
                aw_hold = !m_axi_awready;
                if (m_axi_awready) begin
                    got_aw.push_back({m_axi_awaddr, m_axi_awlen});
                    cur_len = int'(m_axi_awlen);
                    beat    = 0;
                end
            end else aw_hold = 1'b0;

            if (m_axi_wvalid) begin
                if (w_hold) chk("w_stable", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, w_prev);
                w_prev = {m_axi_wdata, m_axi_wstrb, m_axi_wlast};
                w_hold = !m_axi_wready;
                if (m_axi_wready) begin
                    if (exp_data.size() == 0) chk("w_unexpected", 1, 0);
                    else chk("wdata", {m_axi_wstrb, m_axi_wdata}, exp_data.pop_front());
                    chk("wlast", m_axi_wlast, beat == cur_len);
                    beat++;
                    w_beats++;
                end
            end else w_hold = 1'b0;

            if (m_axi_bvalid && m_axi_bready) b_cnt++;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_word(input bit keep);
        logic [35:0] w;
        w = {4'($urandom_range(1, 15)), $urandom};
        data_in = w;
        data_we = 1'b1;
        if (keep) exp_data.push_back(w);
        step(1);
        data_we = 1'b0;
    endtask

    task automatic push_cmd(input logic [7:0] len, input logic [31:0] addr);
        ctrl_in = {len, addr};
        ctrl_we = 1'b1;
        step(1);
        ctrl_we = 1'b0;
    endtask

    task automatic wait_done(input int target_b, input string nm);
        int n = 0;
        while ((b_cnt < target_b || busy) && n < 5000) begin step(1); n++; end
        chk(nm, n < 5000, 1);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ctl"}, {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wlast, busy, err,
                          data_full, ctrl_full}, 0);
        chk({nm, "_aw"}, {m_axi_awaddr, m_axi_awlen}, 0);
        chk({nm, "_w"}, {m_axi_wdata, m_axi_wstrb}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        exp_data.delete();
        got_aw.delete();
        rst_n = 1'b1;
        step(1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0]  len;
        logic [31:0] addr;
        bit          wr;
        int          dly;
        int          np;
        logic [39:0] aw0;
        logic [39:0] aw1;
    } vec_t;

    vec_t vec[6];

    initial begin
        int b0;
        int wb0;
        int n;

        vec[0] = '{8'd64,  32'h0000_0100, 1'b0, 0, 1, {32'h0000_0100, 8'd63},  40'd0};
        vec[1] = '{8'd64,  32'h0000_0FC0, 1'b0, 0, 2, {32'h0000_0FC0, 8'd15},  {32'h0000_1000, 8'd47}};
        vec[2] = '{8'd200, 32'h0000_1F00, 1'b1, 5, 2, {32'h0000_1F00, 8'd63},  {32'h0000_2000, 8'd135}};
        vec[3] = '{8'd1,   32'h0000_0004, 1'b0, 0, 1, {32'h0000_0004, 8'd0},   40'd0};
        vec[4] = '{8'd255, 32'h0000_3FFC, 1'b1, 2, 2, {32'h0000_3FFC, 8'd0},   {32'h0000_4000, 8'd253}};
        vec[5] = '{8'd8,   32'hFFFF_FFE0, 1'b0, 0, 1, {32'hFFFF_FFE0, 8'd7},   40'd0};

        rst_n   = 1'b0;
        data_in = '0;
        data_we = 1'b0;
        ctrl_in = '0;
        ctrl_we = 1'b0;
        #3;
        chk_reset_outs("reset");
        chk("aw_const", {m_axi_awsize, m_axi_awburst}, {3'b010, 2'b01});
        @(posedge clk); #1;
        do_reset();

        // Table: push all data, then the command; check the split and the data.
        for (int i = 0; i < 6; i++) begin
            wrand  = vec[i].wr;
            aw_dly = vec[i].dly;
            b0     = b_cnt;
            got_aw.delete();
            for (int k = 0; k < int'(vec[i].len); k++) push_word(1'b1);
            push_cmd(vec[i].len, vec[i].addr);
            wait_done(b0 + vec[i].np, $sformatf("v%0d_done", i));
            chk($sformatf("v%0d_npieces", i), got_aw.size(), vec[i].np);
            chk($sformatf("v%0d_aw0", i), (got_aw.size() > 0) ? got_aw[0] : '1, vec[i].aw0);
            if (vec[i].np > 1)
                chk($sformatf("v%0d_aw1", i), (got_aw.size() > 1) ? got_aw[1] : '1, vec[i].aw1);
            chk($sformatf("v%0d_drained", i), exp_data.size(), 0);
        end
        wrand  = 1'b0;
        aw_dly = 0;
        chk("err_clean", err, 3'b000);

        // Command ahead of its data: nothing issues until the last word lands.
        b0 = b_cnt;
        got_aw.delete();
        push_cmd(8'd16, 32'h0);
        for (int k = 0; k < 15; k++) push_word(1'b1);
        step(3);
        chk("early_awvalid", {m_axi_awvalid, busy}, 2'b00);
        push_word(1'b1);
        chk("late_t1", m_axi_awvalid, 1'b0);
        step(1);
        chk("late_t2", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, 32'h0, 8'd15});
        wait_done(b0 + 1, "late_done");
        chk("late_drained", exp_data.size(), 0);

        // Command FIFO full with no data behind it.
        do_reset();
        for (int k = 0; k < 16; k++) push_cmd(8'd1, 32'h0);
        chk("cfull", {ctrl_full, busy, err}, {1'b1, 1'b0, 3'b000});
        push_cmd(8'd1, 32'h0);
        chk("cdrop_err", err, 3'b010);
        do_reset();
        chk_reset_outs("reset2");

        // Data overflow: extra word lost, remaining data still in order.
        for (int k = 0; k < 512; k++) push_word(1'b1);
        chk("dfull", {data_full, err}, {1'b1, 3'b000});
        push_word(1'b0);
        chk("ddrop_err", {data_full, err}, {1'b1, 3'b001});
        push_cmd(8'd0, 32'h40);
        chk("len0_err", err, 3'b101);
        b0 = b_cnt;
        push_cmd(8'd255, 32'h0);
        push_cmd(8'd255, 32'h8000);
        push_cmd(8'd2, 32'h9000);
        wait_done(b0 + 3, "ovf_done");
        chk("ovf_drained", exp_data.size(), 0);
        b0 = b_cnt;
        push_word(1'b1);
        push_cmd(8'd1, 32'h40);
        wait_done(b0 + 1, "ovf_tail_done");
        chk("ovf_tail_drained", {exp_data.size(), data_full}, 0);

        // Error response.
        do_reset();
        bresp_cfg = 2'b10;
        b0 = b_cnt;
        push_word(1'b1);
        push_cmd(8'd1, 32'h0);
        wait_done(b0 + 1, "bresp_done");
        chk("bresp_err", err, 3'b100);
        bresp_cfg = 2'b00;

        // Reset mid-burst, then a fresh command completes.
        do_reset();
        wb0 = w_beats;
        for (int k = 0; k < 32; k++) push_word(1'b1);
        push_cmd(8'd32, 32'h200);
        n = 0;
        while (w_beats - wb0 < 10 && n < 500) begin step(1); n++; end
        chk("mid_reach10", n < 500, 1);
        chk("mid_in_data", m_axi_wvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_reset");
        step(1);
        exp_data.delete();
        got_aw.delete();
        rst_n = 1'b1;
        step(1);
        b0 = b_cnt;
        for (int k = 0; k < 8; k++) push_word(1'b1);
        push_cmd(8'd8, 32'h300);
        wait_done(b0 + 1, "post_done");
        chk("post_aw", (got_aw.size() == 1) ? got_aw[0] : '1, {32'h300, 8'd7});
        chk("post_drained", {exp_data.size(), err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
